// File: rtl/sid_pot_sched_if.sv
// rtl/sid_pot_sched_if.sv - result/select bus of the SID POT port scheduler
interface sid_pot_sched_if #(
  parameter int NPORTS = 2
);
  localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [SW-1:0]              mux_sel;
  logic [NPORTS-1:0][1:0][7:0] pot_val;
  logic [NPORTS-1:0]          pot_valid;
  logic                       upd;
  logic [SW-1:0]              upd_port;

  modport master (output mux_sel, pot_val, pot_valid, upd, upd_port);
  modport slave  (input  mux_sel, pot_val, pot_valid, upd, upd_port);
endinterface

// File: rtl/sid_pot_sched.sv
// rtl/sid_pot_sched.sv - time-multiplexes the SID POTX/POTY datapath across paddle ports
// Optional feature macro: SID_POT_SCHED_HYST_EN (per-axis 1-LSB capture hysteresis).
package sid;
  typedef logic [3:0] phase_t;
  localparam int PHI1      = 0;
  localparam int PHI1_PHI2 = 1;
  localparam int PHI2      = 2;
  localparam int PHI2_PHI1 = 3;

  typedef struct packed {
    logic [1:0][7:0] xy;
  } pot_reg_t;
endpackage

module sid_pot_sched #(
  parameter int NPORTS        = 2,
  parameter int SETTLE_ROUNDS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  sid::phase_t       phase,
  input  logic              en,
  input  logic              pot_discharge,
  input  sid::pot_reg_t     pot_reg,
  sid_pot_sched_if.master   bus
);
  localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [SW-1:0] LAST_PORT = SW'(NPORTS - 1);
  localparam logic [1:0]    SETTLE_LOAD = 2'(SETTLE_ROUNDS);

  typedef enum logic [1:0] {SYNC, SETTLE, MEASURE, PARK} state_t;
  localparam state_t FIRST_STATE = (SETTLE_ROUNDS == 0) ? MEASURE : SETTLE;

  state_t                      state;
  logic                        disch_q;
  logic [1:0]                  settle;
  logic [SW-1:0]               mux_sel;
  logic [SW-1:0]               next_port;
  logic [SW-1:0]               upd_port;
  logic [NPORTS-1:0][1:0][7:0] pot_val;
  logic [NPORTS-1:0]           pot_valid;
  logic                        upd;

  logic                        tick;
  logic                        evt;
  logic [SW-1:0]               mux_inc;
  logic [1:0][7:0]             cap_val;
  logic                        unused_phase;

  assign tick         = phase[sid::PHI1_PHI2];
  assign unused_phase = ^phase;
  // Round boundary: discharge half just started, so pot_reg holds a full charge measurement
  assign evt          = tick & pot_discharge & ~disch_q;
  assign mux_inc      = (mux_sel == LAST_PORT) ? '0 : mux_sel + 1'b1;

`ifdef SID_POT_SCHED_HYST_EN
  function automatic logic near(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return diff < 8'd2;
  endfunction

  always_comb begin
    cap_val = pot_val[mux_sel];
    for (int a = 0; a < 2; a++) begin
      if (!pot_valid[mux_sel] || !near(pot_val[mux_sel][a], pot_reg.xy[a]))
        cap_val[a] = pot_reg.xy[a];
    end
  end
`else
  always_comb begin
    cap_val = pot_reg.xy;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SYNC;
      disch_q   <= 1'b1;
      settle    <= '0;
      mux_sel   <= '0;
      next_port <= '0;
      upd_port  <= '0;
      pot_val   <= '0;
      pot_valid <= '0;
      upd       <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (tick) begin
        disch_q <= pot_discharge;
        case (state)
          SYNC: begin
            if (evt) begin
              if (en) begin
                mux_sel <= next_port;
                settle  <= SETTLE_LOAD;
                state   <= FIRST_STATE;
              end else begin
                state <= PARK;
              end
            end
          end
          SETTLE: begin
            if (evt) begin
              if (!en) begin
                state <= PARK;
              end else begin
                settle <= settle - 2'd1;
                if (settle == 2'd1)
                  state <= MEASURE;
              end
            end
          end
          MEASURE: begin
            if (evt) begin
              pot_val[mux_sel]   <= cap_val;
              pot_valid[mux_sel] <= 1'b1;
              upd                <= 1'b1;
              upd_port           <= mux_sel;
              if (en) begin
                mux_sel <= mux_inc;
                settle  <= SETTLE_LOAD;
                state   <= FIRST_STATE;
              end else begin
                state <= PARK;
              end
            end
          end
          PARK: begin
            // Resume with the port after the last one selected; SYNC waits for a clean boundary
            if (en) begin
              next_port <= mux_inc;
              state     <= SYNC;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  assign bus.mux_sel   = mux_sel;
  assign bus.pot_val   = pot_val;
  assign bus.pot_valid = pot_valid;
  assign bus.upd       = upd;
  assign bus.upd_port  = upd_port;
endmodule

// File: tb/tb_sid_pot_sched.sv
// tb/tb_sid_pot_sched.sv - directed bench for sid_pot_sched (2-port/1-settle and 3-port/0-settle)
module tb_sid_pot_sched;
  localparam int HALF = 256;
  localparam sid::phase_t TICK = 4'b0010;
  localparam sid::phase_t IDLE = 4'b1101;

  logic          clk = 1'b0;
  logic          rst_n;
  sid::phase_t   phase;
  logic          en_a, en_b;
  logic          pot_discharge;
  sid::pot_reg_t pot_reg;

  sid_pot_sched_if #(.NPORTS(2)) bus_a ();
  sid_pot_sched_if #(.NPORTS(3)) bus_b ();

  sid_pot_sched #(.NPORTS(2), .SETTLE_ROUNDS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .phase(phase), .en(en_a),
    .pot_discharge(pot_discharge), .pot_reg(pot_reg), .bus(bus_a)
  );
  sid_pot_sched #(.NPORTS(3), .SETTLE_ROUNDS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .phase(phase), .en(en_b),
    .pot_discharge(pot_discharge), .pot_reg(pot_reg), .bus(bus_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int upd_cnt_a = 0;
  int upd_cnt_b = 0;

  always @(negedge clk) begin
    if (bus_a.upd === 1'b1) upd_cnt_a++;
    if (bus_b.upd === 1'b1) upd_cnt_b++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit t, input bit d);
    phase = t ? TICK : IDLE;
    pot_discharge = d;
    @(negedge clk);
  endtask

  // Charge half, then the E tick; returns at the negedge just after the E edge.
  task automatic run_to_e(input logic [7:0] x, input logic [7:0] y);
    pot_reg.xy[0] = x;
    pot_reg.xy[1] = y;
    for (int i = 0; i < HALF; i++) begin
      drive(1, 0);
      drive(0, 0);
    end
    drive(1, 1);
  endtask

  task automatic finish_round();
    for (int i = 0; i < HALF - 1; i++) begin
      drive(1, 1);
      drive(0, 1);
    end
  endtask

  typedef struct {
    logic [7:0] x, y;
    bit en_a;
    bit a_upd; int a_port; int a_mux;
    bit b_upd; int b_port; int b_mux;
  } vec_t;

  function automatic vec_t mk(logic [7:0] x, logic [7:0] y, bit ea, bit au, int ap, int am,
                              bit bu, int bp, int bm);
    vec_t v;
    v.x = x; v.y = y; v.en_a = ea;
    v.a_upd = au; v.a_port = ap; v.a_mux = am;
    v.b_upd = bu; v.b_port = bp; v.b_mux = bm;
    return v;
  endfunction

  vec_t vecs[18];
  logic [15:0] ea_val[2];
  logic [15:0] eb_val[3];
  logic [1:0]  ea_vld;
  logic [2:0]  eb_vld;

`ifdef SID_POT_SCHED_HYST_EN
  logic [15:0] hyst_exp[4] = '{16'h8080, 16'h8280, 16'h8280, 16'h9083};
`else
  logic [15:0] hyst_exp[4] = '{16'h8080, 16'h8281, 16'h817F, 16'h9083};
`endif
  logic [7:0] hx[11] = '{8'h11, 8'h80, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h83};
  logic [7:0] hy[11] = '{8'h11, 8'h80, 8'h00, 8'h00, 8'h82, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h90};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_b, hidx;
    logic [63:0] snap_val_a, snap_val_b;
    logic [7:0]  snap_misc;

    vecs[0]  = mk(8'h11, 8'h22, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(8'h33, 8'h44, 1, 0, 0, 0, 1, 0, 1);
    vecs[2]  = mk(8'h40, 8'h80, 1, 1, 0, 1, 1, 1, 2);
    vecs[3]  = mk(8'h55, 8'h66, 1, 0, 0, 1, 1, 2, 0);
    vecs[4]  = mk(8'h10, 8'hF0, 1, 1, 1, 0, 1, 0, 1);
    vecs[5]  = mk(8'h77, 8'h99, 1, 0, 1, 0, 1, 1, 2);
    vecs[6]  = mk(8'hA5, 8'h5A, 1, 1, 0, 1, 1, 2, 0);
    vecs[7]  = mk(8'hC1, 8'h1C, 1, 0, 0, 1, 1, 0, 1);
    vecs[8]  = mk(8'h2B, 8'hB2, 0, 1, 1, 1, 1, 1, 2);
    vecs[9]  = mk(8'h3C, 8'hC3, 0, 0, 1, 1, 1, 2, 0);
    vecs[10] = mk(8'h4D, 8'hD4, 0, 0, 1, 1, 1, 0, 1);
    vecs[11] = mk(8'h5E, 8'hE5, 0, 0, 1, 1, 1, 1, 2);
    vecs[12] = mk(8'h6F, 8'hF6, 0, 0, 1, 1, 1, 2, 0);
    vecs[13] = mk(8'h70, 8'h07, 1, 0, 1, 0, 1, 0, 1);
    vecs[14] = mk(8'h81, 8'h18, 1, 0, 1, 0, 1, 1, 2);
    vecs[15] = mk(8'h92, 8'h29, 1, 1, 0, 1, 1, 2, 0);
    vecs[16] = mk(8'hA3, 8'h3A, 0, 0, 0, 1, 1, 0, 1);
    vecs[17] = mk(8'hB4, 8'h4B, 1, 0, 0, 0, 1, 1, 2);

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    phase = IDLE; pot_discharge = 1'b0; pot_reg = '0;
    ea_val = '{default: '0}; eb_val = '{default: '0};
    ea_vld = '0; eb_vld = '0;
    @(negedge clk);
    repeat (4) drive(1, 0);
    rst_n = 1'b1;

    chk("reset a_mux", 64'(bus_a.mux_sel), 0);
    chk("reset a_val", 64'(bus_a.pot_val), 0);
    chk("reset a_valid", 64'(bus_a.pot_valid), 0);
    chk("reset a_upd", 64'(bus_a.upd), 0);
    chk("reset a_port", 64'(bus_a.upd_port), 0);
    chk("reset b_mux", 64'(bus_b.mux_sel), 0);
    chk("reset b_val", 64'(bus_b.pot_val), 0);
    chk("reset b_valid", 64'(bus_b.pot_valid), 0);
    chk("reset b_upd", 64'(bus_b.upd), 0);
    chk("reset b_port", 64'(bus_b.upd_port), 0);

    // Main scan: one row per round, outputs compared just after the boundary edge.
    base_a = upd_cnt_a; base_b = upd_cnt_b;
    en_b = 1'b1;
    for (int r = 0; r < 18; r++) begin
      en_a = vecs[r].en_a;
      run_to_e(vecs[r].x, vecs[r].y);
      if (vecs[r].a_upd) begin
        ea_val[vecs[r].a_port] = {vecs[r].y, vecs[r].x};
        ea_vld[vecs[r].a_port] = 1'b1;
      end
      if (vecs[r].b_upd) begin
        eb_val[vecs[r].b_port] = {vecs[r].y, vecs[r].x};
        eb_vld[vecs[r].b_port] = 1'b1;
      end
      chk($sformatf("row%0d a_upd", r + 1), 64'(bus_a.upd), 64'(vecs[r].a_upd));
      chk($sformatf("row%0d a_port", r + 1), 64'(bus_a.upd_port), 64'(vecs[r].a_port));
      chk($sformatf("row%0d a_mux", r + 1), 64'(bus_a.mux_sel), 64'(vecs[r].a_mux));
      chk($sformatf("row%0d b_upd", r + 1), 64'(bus_b.upd), 64'(vecs[r].b_upd));
      chk($sformatf("row%0d b_port", r + 1), 64'(bus_b.upd_port), 64'(vecs[r].b_port));
      chk($sformatf("row%0d b_mux", r + 1), 64'(bus_b.mux_sel), 64'(vecs[r].b_mux));
      chk($sformatf("row%0d a_valid", r + 1), 64'(bus_a.pot_valid), 64'(ea_vld));
      chk($sformatf("row%0d b_valid", r + 1), 64'(bus_b.pot_valid), 64'(eb_vld));
      for (int p = 0; p < 2; p++)
        chk($sformatf("row%0d a_val%0d", r + 1, p), 64'(bus_a.pot_val[p]), 64'(ea_val[p]));
      for (int p = 0; p < 3; p++)
        chk($sformatf("row%0d b_val%0d", r + 1, p), 64'(bus_b.pot_val[p]), 64'(eb_val[p]));
      drive(0, 1);
      chk($sformatf("row%0d a_upd_clr", r + 1), 64'(bus_a.upd), 0);
      chk($sformatf("row%0d b_upd_clr", r + 1), 64'(bus_b.upd), 0);
      finish_round();
    end
    chk("scan a_upd_count", 64'(upd_cnt_a - base_a), 5);
    chk("scan b_upd_count", 64'(upd_cnt_b - base_b), 17);

    // Reset lands mid-discharge: the partial discharge must not count as a boundary.
    drive(1, 1);
    rst_n = 1'b0;
    repeat (3) drive(1, 1);
    rst_n = 1'b1;
    base_a = upd_cnt_a; base_b = upd_cnt_b;
    for (int i = 0; i < 100; i++) begin
      drive(1, 1);
      drive(0, 1);
    end
    chk("midrst a_upd_count", 64'(upd_cnt_a - base_a), 0);
    chk("midrst b_upd_count", 64'(upd_cnt_b - base_b), 0);
    chk("midrst a_mux", 64'(bus_a.mux_sel), 0);
    chk("midrst b_valid", 64'(bus_b.pot_valid), 0);

    // Port 0 of the 3-port instance sees 0x80, then near/far values per axis.
    hidx = 0;
    for (int r = 1; r <= 11; r++) begin
      run_to_e(hx[r-1], hy[r-1]);
      chk($sformatf("post%0d a_upd", r), 64'(bus_a.upd), 64'((r >= 3) && (r % 2 == 1)));
      chk($sformatf("post%0d b_upd", r), 64'(bus_b.upd), 64'(r >= 2));
      if (r % 3 == 2) begin
        chk($sformatf("post%0d b_port", r), 64'(bus_b.upd_port), 0);
        chk($sformatf("post%0d b_val0", r), 64'(bus_b.pot_val[0]), 64'(hyst_exp[hidx]));
        hidx++;
      end
      drive(0, 1);
      finish_round();
    end
    chk("post a_mux", 64'(bus_a.mux_sel), 1);

    // Phase strobe held low while discharge toggles: nothing may move.
    snap_val_a = 64'(bus_a.pot_val);
    snap_val_b = 64'(bus_b.pot_val);
    snap_misc  = {bus_a.mux_sel, bus_a.upd_port, bus_a.pot_valid, bus_b.mux_sel, bus_b.upd_port[0]};
    base_a = upd_cnt_a; base_b = upd_cnt_b;
    for (int i = 0; i < 1000; i++) begin
      phase = 4'b0000;
      pot_discharge = 1'((i / 10) % 2);
      @(negedge clk);
    end
    chk("nophase a_val", 64'(bus_a.pot_val), snap_val_a);
    chk("nophase b_val", 64'(bus_b.pot_val), snap_val_b);
    chk("nophase misc", 64'({bus_a.mux_sel, bus_a.upd_port, bus_a.pot_valid, bus_b.mux_sel,
                            bus_b.upd_port[0]}), 64'(snap_misc));
    chk("nophase b_mux", 64'(bus_b.mux_sel), 1);
    chk("nophase a_upd_count", 64'(upd_cnt_a - base_a), 0);
    chk("nophase b_upd_count", 64'(upd_cnt_b - base_b), 0);

    run_to_e(8'h5A, 8'hA5);
    chk("resume a_upd", 64'(bus_a.upd), 0);
    chk("resume a_mux", 64'(bus_a.mux_sel), 1);
    chk("resume b_upd", 64'(bus_b.upd), 1);
    chk("resume b_port", 64'(bus_b.upd_port), 1);
    chk("resume b_mux", 64'(bus_b.mux_sel), 2);
    chk("resume b_val1", 64'(bus_b.pot_val[1]), 64'h0000_0000_0000_A55A);
    drive(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sid_pot_sched.md
# sid_pot_sched

Time-multiplexing scheduler that shares the single SID POTX/POTY measurement datapath (`sid_pot`) between several paddle ports. It drives an external analog multiplexer select and advances only during the discharge half of a 512-cycle POT round, so every capture is a clean full round for one port. Per-port results are held in a result bank with valid flags and an update strobe for the bus/register layer. It sits beside `sid_pot` in the SID core, clocked by the same phase strobes.

## Interface
- NPORTS, 2: number of paddle ports sharing POTX/POTY; legal 2..8.
- SETTLE_ROUNDS, 1: full rounds discarded after each mux switch; legal 0..3.
- SW: local, max($clog2(NPORTS),1), select width.

Ports:
- clk  in  1  system clock; one clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- phase  in  sid::phase_t  phase strobes; only `phase[sid::PHI1_PHI2]` advances state.
- en  in  1  scheduling enable.
- pot_discharge  in  1  `pot_o.discharge` from `sid_pot` (counter bit 8).
- pot_reg  in  sid::pot_reg_t  current POTX/POTY register values (`xy[0]`, `xy[1]`).
- mux_sel  out  SW  analog mux select, port being measured.
- pot_val  out  [NPORTS][2][8]  captured X/Y per port.
- pot_valid  out  NPORTS  port holds at least one capture.
- upd  out  1  one-clk pulse on capture.
- upd_port  out  SW  port index of last capture.

## Operation
- All state changes occur only on clocks where `phase[sid::PHI1_PHI2]` = 1 ("tick"), except `upd` deassert.
- Round boundary event E: tick where `pot_discharge` = 1 and `disch_q` = 0; `disch_q` samples `pot_discharge` each tick.
- At E, `pot_reg` holds the completed charge-phase measurement of the round ending.
- FSM states:
  - SYNC: after reset or re-enable. At E with `en`=1: `mux_sel`<=next port (0 after reset), `settle`<=SETTLE_ROUNDS, go SETTLE (or MEASURE if SETTLE_ROUNDS=0). No capture.
  - SETTLE: at E, `settle`<=settle-1; on reaching 0 go MEASURE.
  - MEASURE: at E, capture `pot_reg.xy` into `pot_val[mux_sel]`, set `pot_valid[mux_sel]`, pulse `upd`, `upd_port`<=mux_sel; then if `en`=1 advance `mux_sel` (wrap NPORTS-1 -> 0), reload settle, go SETTLE/MEASURE; if `en`=0 go PARK.
  - PARK: `mux_sel` held, no captures; when `en`=1 go SYNC, next port = `mux_sel`+1 (wrapped).
- `en` deasserted in SETTLE/SYNC: current round abandoned at next E, go PARK, no capture.
- Mux switches only at E (start of 256-cycle discharge), never in charge half.
- Per-port cycle: (SETTLE_ROUNDS+1) rounds; full scan NPORTS×(SETTLE_ROUNDS+1)×512 ticks.

## Timing
- Reset values: `mux_sel`=0, `pot_val`=all 0, `pot_valid`=0, `upd`=0, `upd_port`=0, state SYNC, `disch_q`=1 (suppresses false E if reset lands mid-discharge; first E is next genuine 0->1).
- Capture latency: outputs updated on the clock edge of the E tick; `upd` high exactly one clk, cleared next clk regardless of phase.
- Reset mid-round: first capture occurs no earlier than (SETTLE_ROUNDS+1) full rounds after the first E; no partial-round data ever captured.
- `en` toggles between E events have effect only at the next E.

## Configuration
- `SID_POT_SCHED_HYST_EN`: defined -> per-axis 1-LSB hysteresis: on capture, `pot_val` updated only if |new-old| >= 2 or port not yet valid; `upd` still pulses. Undefined -> every capture overwrites unconditionally.

## Test plan
- Reset then en=1, NPORTS=2, SETTLE_ROUNDS=1, model drives xy=0x40/0x80 for port 0, 0x10/0xF0 for port 1 -> first `upd` at 3rd E after reset with upd_port=0, pot_val[0]=0x40/0x80; port 1 captured 2 rounds later; valid=2'b11.
- Reset asserted while pot_discharge=1 -> no E until the next 0->1 transition; no capture in that partial round.
- SETTLE_ROUNDS=0, NPORTS=3 -> captures every E, upd_port sequence 0,1,2,0; mux_sel wraps 2->0.
- en dropped mid-MEASURE -> capture at next E, then PARK with mux_sel constant and no upd for ≥4 rounds; en=1 -> SYNC, next port measured.
- HYST_EN defined, port value 0x80 then captures 0x81, 0x7F, 0x83 -> pot_val stays 0x80, 0x80, then 0x83; upd pulses each time.
- phase strobe held low for 1000 clks with discharge toggling -> no state, mux_sel, or output change.
